// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_port_arbiter
// Description : Per-output-port wormhole arbiter for the mesh router.
//               Picks one requesting input whose FIFO head is a HEADER flit,
//               using a round-robin pointer, and holds that grant until the
//               packet's TAIL flit has been forwarded. Downstream buffer
//               credits gate every flit transfer.
// Ports       : clk        - clock
//               rst        - asynchronous reset, active low
//               req        - per-input routing request for this output
//               valid      - per-input FIFO non-empty
//               flit_id    - per-input head flit id, input i at [i*FLIT_ID_W +: FLIT_ID_W]
//               credit_in  - downstream freed one buffer slot (1-cycle pulse)
//               grant      - registered one-hot grant, 0 when idle
//               sel        - index of granted input (crossbar select)
//               locked     - a packet owns the output
//               fire       - flit transfer this cycle (read enable of input sel)
//               credit_cnt - available downstream credits
//               credit_err - sticky credit overflow flag
//               timeout    - 1-cycle pulse on forced release
// Options     : ARB_TIMEOUT_EN - when defined, a lock with no transfer for
//               TIMEOUT consecutive cycles is forcibly released.
// Revision    : 1.0 - initial release
// ============================================================================
module output_port_arbiter #(
   parameter int NPORTS    = 5,
   parameter int FLIT_ID_W = 3,
   parameter int CREDITS   = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NPORTS-1:0]              req,
   input  logic [NPORTS-1:0]              valid,
   input  logic [NPORTS*FLIT_ID_W-1:0]    flit_id,
   input  logic                           credit_in,
   output logic [NPORTS-1:0]              grant,
   output logic [$clog2(NPORTS)-1:0]      sel,
   output logic                           locked,
   output logic                           fire,
   output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
   output logic                           credit_err,
   output logic                           timeout
);

   localparam int c_SEL_W = $clog2(NPORTS);
   localparam int c_CNT_W = $clog2(CREDITS+1);

   // Flit id encoding shared with the rest of the router
   localparam logic [FLIT_ID_W-1:0] c_HEADER  = FLIT_ID_W'(1);
   localparam logic [FLIT_ID_W-1:0] c_PAYLOAD = FLIT_ID_W'(2);
   localparam logic [FLIT_ID_W-1:0] c_TAIL    = FLIT_ID_W'(4);

   localparam logic [c_CNT_W-1:0] c_CREDITS_MAX = c_CNT_W'(CREDITS);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [NPORTS-1:0]    r_grant;
   logic [NPORTS-1:0]    w_grant_next;
   logic [c_SEL_W-1:0]   r_sel;
   logic [c_SEL_W-1:0]   w_sel_next;
   logic [c_SEL_W-1:0]   r_ptr;
   logic [c_SEL_W-1:0]   w_ptr_next;
   logic [c_CNT_W-1:0]   r_credit_cnt;
   logic [c_CNT_W-1:0]   w_credit_next;
   logic                 r_credit_err;
   logic                 w_credit_ovf;

   logic [FLIT_ID_W-1:0] w_fid [NPORTS];
   logic [NPORTS-1:0]    w_cand;
   logic                 w_found;
   logic [c_SEL_W-1:0]   w_win;
   logic                 w_fire;
   logic                 w_tail;
   logic                 w_expire;

   // Per-input flit id slices and header candidates
   for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      assign w_fid[gi]  = flit_id[gi*FLIT_ID_W +: FLIT_ID_W];
      assign w_cand[gi] = req[gi] & valid[gi] & (w_fid[gi] == c_HEADER);
   end

   // Round-robin search: indices above the pointer first, then wrap around
   // to indices at or below it, so the last owner has lowest priority.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (!w_found && w_cand[i] && (c_SEL_W'(i) > r_ptr)) begin
            w_found = 1'b1;
            w_win   = c_SEL_W'(i);
         end
      end
      for (int i = 0; i < NPORTS; i++) begin
         if (!w_found && w_cand[i] && (c_SEL_W'(i) <= r_ptr)) begin
            w_found = 1'b1;
            w_win   = c_SEL_W'(i);
         end
      end
   end

   assign w_fire = (r_state == S_LOCK) && valid[r_sel] && (r_credit_cnt != '0);
   assign w_tail = w_fire && (w_fid[r_sel] == c_TAIL);

`ifdef ARB_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT+1);

   logic [c_TO_W-1:0] r_idle_cnt;
   logic              r_timeout;

   // Expire on the cycle that would bring the idle count up to TIMEOUT.
   assign w_expire = (r_state == S_LOCK) && !w_fire &&
                     (r_idle_cnt == c_TO_W'(TIMEOUT-1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idle_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (r_state == S_IDLE || w_fire || w_expire) begin
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
         end
      end
   end

   assign timeout = r_timeout;
`else
   assign w_expire = 1'b0;
   assign timeout  = 1'b0;
`endif

   // Next-state and grant logic
   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      w_sel_next   = r_sel;
      w_ptr_next   = r_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_next = S_LOCK;
               w_grant_next = NPORTS'(1) << w_win;
               w_sel_next   = w_win;
            end
         end
         S_LOCK: begin
            if (w_tail || w_expire) begin
               w_state_next = S_IDLE;
               w_grant_next = '0;
               w_ptr_next   = r_sel;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_grant_next = '0;
         end
      endcase
   end

   // Credit accounting; a simultaneous transfer and return cancel out.
   assign w_credit_ovf = credit_in && (r_credit_cnt == c_CREDITS_MAX);

   always_comb begin
      w_credit_next = r_credit_cnt;
      case ({w_fire, credit_in})
         2'b10:   w_credit_next = r_credit_cnt - c_CNT_W'(1);
         2'b01:   if (r_credit_cnt != c_CREDITS_MAX) w_credit_next = r_credit_cnt + c_CNT_W'(1);
         default: w_credit_next = r_credit_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_sel        <= '0;
         r_ptr        <= c_SEL_W'(NPORTS-1);
         r_credit_cnt <= c_CREDITS_MAX;
         r_credit_err <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_grant      <= w_grant_next;
         r_sel        <= w_sel_next;
         r_ptr        <= w_ptr_next;
         r_credit_cnt <= w_credit_next;
         if (w_credit_ovf) begin
            r_credit_err <= 1'b1;
         end
      end
   end

   assign grant      = r_grant;
   assign sel        = r_sel;
   assign locked     = (r_state == S_LOCK);
   assign fire       = w_fire;
   assign credit_cnt = r_credit_cnt;
   assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_port_arbiter
// Description : Self-checking bench for output_port_arbiter. Directed
//               scenarios plus randomized traffic, all compared against a
//               packet-level reference model (owner index, pointer, credits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_port_arbiter;

   localparam int c_NP = 5;
   localparam int c_FW = 3;
   localparam int c_CR = 4;
   localparam int c_TO = 16;

   localparam logic [c_FW-1:0] c_HDR = 3'b001;
   localparam logic [c_FW-1:0] c_PAY = 3'b010;
   localparam logic [c_FW-1:0] c_TAIL = 3'b100;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [c_NP-1:0]      req;
   logic [c_NP-1:0]      valid;
   logic [c_NP*c_FW-1:0] flit_id;
   logic                 credit_in;
   logic [c_NP-1:0]      grant;
   logic [2:0]           sel;
   logic                 locked;
   logic                 fire;
   logic [2:0]           credit_cnt;
   logic                 credit_err;
   logic                 timeout;

   output_port_arbiter #(
      .NPORTS(c_NP), .FLIT_ID_W(c_FW), .CREDITS(c_CR), .TIMEOUT(c_TO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .valid(valid), .flit_id(flit_id),
      .credit_in(credit_in), .grant(grant), .sel(sel), .locked(locked),
      .fire(fire), .credit_cnt(credit_cnt), .credit_err(credit_err),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: which input owns the output (-1 = none)
   int m_owner;
   int m_ptr;
   int m_cred;
   int m_idle;
   bit m_err;
   bit m_to;

   function automatic logic [c_FW-1:0] fid_of(int i);
      return flit_id[i*c_FW +: c_FW];
   endfunction

   task automatic set_fid(int i, logic [c_FW-1:0] v);
      flit_id[i*c_FW +: c_FW] = v;
   endtask

   function automatic bit exp_fire();
      return (m_owner >= 0) && valid[m_owner] && (m_cred != 0);
   endfunction

   function automatic logic [c_NP-1:0] exp_grant();
      logic [c_NP-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = c_NP - 1;
      m_cred  = c_CR;
      m_idle  = 0;
      m_err   = 1'b0;
      m_to    = 1'b0;
   endtask

   // Advance one clock edge and update the model from the inputs seen there.
   task automatic step();
      bit f;
      f = exp_fire();
      @(posedge clk);
      if (credit_in && m_cred == c_CR) m_err = 1'b1;
      m_cred = m_cred - (f ? 1 : 0) + (credit_in ? 1 : 0);
      if (m_cred > c_CR) m_cred = c_CR;
      m_to = 1'b0;
      if (m_owner < 0) begin
         m_idle = 0;
         for (int k = 1; k <= c_NP; k++) begin
            int i;
            i = (m_ptr + k) % c_NP;
            if (req[i] && valid[i] && fid_of(i) == c_HDR) begin
               m_owner = i;
               break;
            end
         end
      end else if (f && fid_of(m_owner) == c_TAIL) begin
         m_ptr   = m_owner;
         m_owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (f) begin
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle == c_TO) begin
            m_ptr   = m_owner;
            m_owner = -1;
            m_to    = 1'b1;
            m_idle  = 0;
         end
      end
`endif
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      req       = '0;
      valid     = '0;
      flit_id   = '0;
      credit_in = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      checks++; if (grant !== 5'b0) begin errors++; $display("FAIL reset_grant: got %b want %b", grant, 5'b0); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
      checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
      checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL reset_credit: got %0d want 4", credit_cnt); end
      checks++; if (credit_err !== 1'b0 || timeout !== 1'b0 || fire !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got err=%b to=%b fire=%b want 0/0/0", credit_err, timeout, fire);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req = 5'b00110; valid = 5'b00110;
      set_fid(1, c_HDR); set_fid(2, c_HDR);
      #2;
      checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL rr_latency: got %b want 00000", grant); end
      step();
      #2;
      checks++; if (grant !== 5'b00010 || sel !== 3'd1) begin
         errors++; $display("FAIL rr_first: got grant=%b sel=%0d want 00010/1", grant, sel);
      end
      checks++; if (fire !== 1'b1) begin errors++; $display("FAIL rr_hdr_fire: got %b want 1", fire); end
      step();
      set_fid(1, c_TAIL);
      #2;
      checks++; if (fire !== 1'b1) begin errors++; $display("FAIL rr_tail_fire: got %b want 1", fire); end
      step();
      #2;
      checks++; if (grant !== 5'b00000 || locked !== 1'b0) begin
         errors++; $display("FAIL rr_gap: got grant=%b locked=%b want 00000/0", grant, locked);
      end
      step();
      #2;
      checks++; if (grant !== 5'b00100 || sel !== 3'd2) begin
         errors++; $display("FAIL rr_second: got grant=%b sel=%0d want 00100/2", grant, sel);
      end
      checks++; if (credit_cnt !== 3'd2) begin errors++; $display("FAIL rr_credit: got %0d want 2", credit_cnt); end
   endtask

   task automatic test_packet();
      logic [c_FW-1:0] seq [4];
      seq[0] = c_HDR; seq[1] = c_PAY; seq[2] = c_PAY; seq[3] = c_TAIL;
      do_reset();
      req = 5'b01000; valid = 5'b01000; set_fid(3, c_HDR);
      #2;
      step();
      for (int k = 0; k < 4; k++) begin
         set_fid(3, seq[k]);
         #2;
         checks++; if (grant !== 5'b01000 || fire !== 1'b1) begin
            errors++; $display("FAIL pkt_fire%0d: got grant=%b fire=%b want 01000/1", k, grant, fire);
         end
         checks++; if (credit_cnt !== 3'(4 - k)) begin
            errors++; $display("FAIL pkt_credit%0d: got %0d want %0d", k, credit_cnt, 4 - k);
         end
         step();
      end
      valid = '0;
      #2;
      checks++; if (credit_cnt !== 3'd0 || locked !== 1'b0 || grant !== 5'b0) begin
         errors++; $display("FAIL pkt_end: got cnt=%0d locked=%b grant=%b want 0/0/00000", credit_cnt, locked, grant);
      end
   endtask

   task automatic test_credit_stall();
      do_reset();
      req = 5'b00001; valid = 5'b00001; set_fid(0, c_HDR);
      #2;
      step();
      for (int k = 0; k < 4; k++) begin
         set_fid(0, (k == 0) ? c_HDR : c_PAY);
         #2;
         step();
      end
      set_fid(0, c_PAY);
      #2;
      checks++; if (fire !== 1'b0 || credit_cnt !== 3'd0) begin
         errors++; $display("FAIL stall_fire: got fire=%b cnt=%0d want 0/0", fire, credit_cnt);
      end
      step();
      credit_in = 1'b1;
      #2;
      checks++; if (grant !== 5'b00001 || fire !== 1'b0) begin
         errors++; $display("FAIL stall_hold: got grant=%b fire=%b want 00001/0", grant, fire);
      end
      step();
      credit_in = 1'b0;
      #2;
      checks++; if (fire !== 1'b1 || credit_cnt !== 3'd1) begin
         errors++; $display("FAIL stall_resume: got fire=%b cnt=%0d want 1/1", fire, credit_cnt);
      end
      step();
      #2;
      checks++; if (credit_cnt !== 3'd0 || grant !== 5'b00001) begin
         errors++; $display("FAIL stall_back0: got cnt=%0d grant=%b want 0/00001", credit_cnt, grant);
      end
   endtask

   task automatic test_credit_simul();
      do_reset();
      req = 5'b00100; valid = 5'b00100; set_fid(2, c_HDR);
      #2;
      step();
      step();
      set_fid(2, c_PAY);
      #2;
      step();
      credit_in = 1'b1;
      #2;
      checks++; if (fire !== 1'b1 || credit_cnt !== 3'd2) begin
         errors++; $display("FAIL simul_pre: got fire=%b cnt=%0d want 1/2", fire, credit_cnt);
      end
      step();
      credit_in = 1'b0; valid = '0;
      #2;
      checks++; if (credit_cnt !== 3'd2) begin errors++; $display("FAIL simul_keep: got %0d want 2", credit_cnt); end
      credit_in = 1'b1;
      step();
      step();
      #2;
      checks++; if (credit_cnt !== 3'd4 || credit_err !== 1'b0) begin
         errors++; $display("FAIL simul_full: got cnt=%0d err=%b want 4/0", credit_cnt, credit_err);
      end
      step();
      credit_in = 1'b0;
      #2;
      checks++; if (credit_cnt !== 3'd4 || credit_err !== 1'b1) begin
         errors++; $display("FAIL simul_ovf: got cnt=%0d err=%b want 4/1", credit_cnt, credit_err);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 5'b01000; valid = 5'b01000; set_fid(3, c_HDR);
      #2;
      step();
      #2;
      checks++; if (grant !== 5'b01000 || locked !== 1'b1) begin
         errors++; $display("FAIL rmid_lock: got grant=%b locked=%b want 01000/1", grant, locked);
      end
      step();
      set_fid(3, c_PAY);
      #2;
      checks++; if (credit_cnt !== 3'd3) begin errors++; $display("FAIL rmid_cnt: got %0d want 3", credit_cnt); end
      rst = 1'b0;
      #1;
      model_reset();
      checks++; if (grant !== 5'b0 || locked !== 1'b0 || credit_cnt !== 3'd4) begin
         errors++; $display("FAIL rmid_async: got grant=%b locked=%b cnt=%0d want 00000/0/4", grant, locked, credit_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      req = '1; valid = '1;
      for (int i = 0; i < c_NP; i++) set_fid(i, c_HDR);
      #2;
      step();
      #2;
      checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL rmid_regrant: got %b want 00001", grant); end
   endtask

   task automatic test_hold();
      do_reset();
      req = 5'b00010; valid = 5'b00010; set_fid(1, c_HDR);
      #2;
      step();
      valid = '0;
      #2;
      checks++; if (grant !== 5'b00010) begin errors++; $display("FAIL hold_lock: got %b want 00010", grant); end
`ifdef ARB_TIMEOUT_EN
      repeat (15) step();
      #2;
      checks++; if (grant !== 5'b00010 || timeout !== 1'b0) begin
         errors++; $display("FAIL to_early: got grant=%b to=%b want 00010/0", grant, timeout);
      end
      step();
      #2;
      checks++; if (timeout !== 1'b1 || grant !== 5'b0 || locked !== 1'b0) begin
         errors++; $display("FAIL to_pulse: got to=%b grant=%b locked=%b want 1/00000/0", timeout, grant, locked);
      end
      req = '1; valid = '1;
      for (int i = 0; i < c_NP; i++) set_fid(i, c_HDR);
      step();
      #2;
      checks++; if (timeout !== 1'b0 || grant !== 5'b00100) begin
         errors++; $display("FAIL to_ptr: got to=%b grant=%b want 0/00100", timeout, grant);
      end
`else
      repeat (100) step();
      #2;
      checks++; if (grant !== 5'b00010 || locked !== 1'b1 || timeout !== 1'b0) begin
         errors++; $display("FAIL hold_100: got grant=%b locked=%b to=%b want 00010/1/0", grant, locked, timeout);
      end
`endif
   endtask

   task automatic test_random();
      logic [c_FW-1:0] ids [3];
      ids[0] = c_HDR; ids[1] = c_PAY; ids[2] = c_TAIL;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         req   = c_NP'($urandom);
         valid = c_NP'($urandom | $urandom);
         for (int i = 0; i < c_NP; i++) set_fid(i, ids[$urandom_range(0, 2)]);
         credit_in = ($urandom_range(0, 2) == 0);
         if (n == 200) credit_in = 1'b0;
         #2;
         checks++; if (grant !== exp_grant() || locked !== (m_owner >= 0)) begin
            errors++; $display("FAIL rnd_grant@%0d: got grant=%b locked=%b want %b/%b", n, grant, locked, exp_grant(), m_owner >= 0);
         end
         checks++; if (fire !== exp_fire()) begin
            errors++; $display("FAIL rnd_fire@%0d: got %b want %b", n, fire, exp_fire());
         end
         checks++; if (credit_cnt !== 3'(m_cred) || credit_err !== m_err || timeout !== m_to) begin
            errors++; $display("FAIL rnd_cred@%0d: got cnt=%0d err=%b to=%b want %0d/%b/%b", n, credit_cnt, credit_err, timeout, m_cred, m_err, m_to);
         end
         if (m_owner >= 0) begin
            checks++; if (sel !== 3'(m_owner)) begin
               errors++; $display("FAIL rnd_sel@%0d: got %0d want %0d", n, sel, m_owner);
            end
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_packet();
      test_credit_stall();
      test_credit_simul();
      test_reset_mid();
      test_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
